cpu_result_tx: RTL and testbench
================================

// Module: cpu_result_tx
// PURPOSE
//  Serial result transmitter: the outbound counterpart of the CPU's serial operand loader.
//  On a start request it latches ALU result Y and flags {N,V,Z,C}, then emits one frame.
//  Frame format: a one-cycle frame strobe, then Y MSB-first, then the flags MSB-first.
//  This matches the inbound start-pulse/serial-bit protocol, so an off-chip host can read
//  results on the uio pins without the parallel mux path.
// PARAMETERS
//  DATA_W      8   result width in bits (serialised MSB-first)
//  FLAG_W      4   flag width; flags_i = {N,V,Z,C}, sent bit FLAG_W-1 first
//  SEND_FLAGS  1   1: append flags to frame; 0: frame ends after data
// PORTS
//  clk      in   1       single clock; all state changes on rising edge
//  rst      in   1       synchronous, active-high reset
//  start_i  in   1       request: send current data_i/flags_i (sampled when accepted)
//  data_i   in   DATA_W  ALU result Y
//  flags_i  in   FLAG_W  {N,V,Z,C}
//  busy_o   out  1       high while a frame is in progress (strobe or bit cycles)
//  done_o   out  1       one-cycle pulse after the last bit of a frame
//  fs_o     out  1       frame strobe, high exactly one cycle per frame
//  sdo_o    out  1       serial data out; 0 whenever no bit is being sent
// BEHAVIOUR
//  Reset: state=TX_IDLE; busy_o=done_o=fs_o=sdo_o=0; shift reg=0; bit count=0.
//  Reset wins over everything, including mid-frame; the frame is abandoned, with no done_o.
//  All outputs are registered; none is combinational from an input.
//  FSM states:
//   TX_IDLE: accept start_i=1. Latch {data_i,flags_i} into the shift reg; go to TX_FS.
//   TX_FS: fs_o=1, busy_o=1, sdo_o=0 for one cycle; then go to TX_DATA.
//   TX_DATA: sdo_o=shift MSB; shift left each cycle; DATA_W cycles.
//    Next state is TX_FLAGS if SEND_FLAGS, else TX_IDLE.
//   TX_FLAGS: FLAG_W cycles, same shifting; then go to TX_IDLE.
//  Timing with start_i high at edge k, counted in cycles after k:
//   - fs_o is high in cycle k+1.
//   - data bit DATA_W-1 is in cycle k+2; bit 0 is in cycle k+DATA_W+1.
//   - flags follow in cycles k+DATA_W+2 .. k+DATA_W+FLAG_W+1.
//   - done_o=1 in the following cycle, with busy_o=0 and state TX_IDLE.
//   - For defaults, the frame is 1+8+4=13 cycles, with done_o in cycle k+14.
//  start_i while busy_o=1 is ignored; nothing is queued.
//  start_i in the done_o cycle is accepted (back-to-back frames, no gap cycle).
//  data_i/flags_i changes after acceptance have no effect on the frame in progress.
//  The bit counter is sized clog2(max(DATA_W,FLAG_W)).
//  The counter resets to 0 on each state entry. Counts never wrap past the field length.
//  In TX_IDLE (except the done_o cycle): sdo_o=0, fs_o=0.
// STRUCTURE
//  The TX_IDLE/TX_FS/TX_DATA/TX_FLAGS encodings go in states.vh alongside the existing
//  FSM states. No operation or mux constants are needed.
//  No sub-module: the FSM, the (DATA_W+FLAG_W)-bit shift reg and the bit counter live in
//  one always block plus output regs.
//  Top level: start_i is driven by the control FSM's result-ready pulse.
//  Top level: data_i comes from ALU Y; flags_i comes from the flags register.
//  Top level: sdo_o and fs_o go to uio_out pins with uio_oe set.
// TESTING
//  1. Reset check: assert rst for 2 cycles -> busy_o=done_o=fs_o=sdo_o=0;
//     start_i during rst -> no frame.
//  2. Basic frame: Y=8'hA5, flags=4'b1010, one start_i pulse -> fs_o 1 cycle, then
//     sdo = 1,0,1,0,0,1,0,1, 1,0,1,0; done_o in cycle k+14; busy_o high for 13 cycles.
//  3. Input stability: change data_i to 8'h00 one cycle after acceptance
//     -> frame still carries 8'hA5.
//  4. Ignored and back-to-back starts:
//     - start_i held high through a frame -> a second frame starts in the done_o cycle.
//     - A pulse mid-frame alone -> no extra frame.
//  5. Mid-frame reset: rst at the 5th data bit -> next cycle all outputs 0, no done_o;
//     a new start_i afterwards sends a full, correct frame (Y=8'h3C, flags=4'b0001).
//  6. SEND_FLAGS=0 instance: Y=8'hFF -> 8 ones after fs_o, done_o in cycle k+10.
//  End-to-end: Y=15 (ADD 10+5), flags Z=0 -> decoded frame equals 8'd15, 4'b0000.

Source files
------------

// File: rtl/cpu_result_tx_pkg.sv
// cpu_result_tx_pkg: state encodings and sizing helper for the serial result transmitter
package cpu_result_tx_pkg;
  typedef enum logic [1:0] {TX_IDLE, TX_FS, TX_DATA, TX_FLAGS} tx_state_e;
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/cpu_result_tx.sv
// cpu_result_tx: frames ALU result and flags as strobe + MSB-first serial bits
module cpu_result_tx
  import cpu_result_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FLAG_W     = 4,
  parameter bit SEND_FLAGS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fs_o,
  output logic              sdo_o
);
  localparam int SR_W  = DATA_W + FLAG_W;
  localparam int CNT_W = cnt_w(DATA_W, FLAG_W);
  tx_state_e        state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, fs_q, fs_d, sdo_q, sdo_d;
  logic             emit;
  logic             last;
  // outputs are computed for the upcoming state and registered alongside it
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    fs_d    = 1'b0;
    sdo_d   = 1'b0;
    emit    = 1'b0;
    last    = (state_q == TX_DATA) ? (cnt_q == CNT_W'(DATA_W - 1))
                                   : (cnt_q == CNT_W'(FLAG_W - 1));
    case (state_q)
      TX_IDLE: if (start_i) begin
        state_d = TX_FS;
        sr_d    = {data_i, flags_i};
        cnt_d   = '0;
        busy_d  = 1'b1;
        fs_d    = 1'b1;
      end
      TX_FS: begin
        state_d = TX_DATA;
        cnt_d   = '0;
        emit    = 1'b1;
      end
      TX_DATA: begin
        state_d = !last ? TX_DATA : (SEND_FLAGS ? TX_FLAGS : TX_IDLE);
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        emit    = !last || SEND_FLAGS;
        done_d  = last && !SEND_FLAGS;
      end
      TX_FLAGS: begin
        state_d = last ? TX_IDLE : TX_FLAGS;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        emit    = !last;
        done_d  = last;
      end
      default: state_d = TX_IDLE;
    endcase
    if (emit) begin
      busy_d = 1'b1;
      sdo_d  = sr_q[SR_W-1];
      sr_d   = sr_q << 1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fs_q    <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fs_q    <= fs_d;
      sdo_q   <= sdo_d;
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign fs_o   = fs_q;
  assign sdo_o  = sdo_q;
endmodule

// File: tb/tb_cpu_result_tx.sv
// tb_cpu_result_tx: directed frames checked against a queue of expected serial bits
module tb_cpu_result_tx;
  logic clk = 1'b0;
  logic rst, start_i, start_nf, sel;
  logic [7:0] data_i;
  logic [3:0] flags_i;
  logic busy, done, fs, sdo, nf_busy, nf_done, nf_fs, nf_sdo;
  logic o_busy, o_done, o_fs, o_sdo;
  logic [11:0] rx_word;
  logic exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_result_tx u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .data_i(data_i), .flags_i(flags_i),
    .busy_o(busy), .done_o(done), .fs_o(fs), .sdo_o(sdo)
  );
  cpu_result_tx #(.SEND_FLAGS(1'b0)) u_nf (
    .clk(clk), .rst(rst), .start_i(start_nf), .data_i(data_i), .flags_i(flags_i),
    .busy_o(nf_busy), .done_o(nf_done), .fs_o(nf_fs), .sdo_o(nf_sdo)
  );

  assign o_busy = sel ? nf_busy : busy;
  assign o_done = sel ? nf_done : done;
  assign o_fs   = sel ? nf_fs   : fs;
  assign o_sdo  = sel ? nf_sdo  : sdo;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_nf = v;
    else start_i = v;
  endtask

  task automatic push_frame(input logic [7:0] d, input logic [3:0] f, input bit with_flags);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    if (with_flags) for (int i = 3; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] f, input bit hold);
    data_i  = d;
    flags_i = f;
    push_frame(d, f, !sel);
    set_start(1'b1);
    tick();
    if (!hold) set_start(1'b0);
  endtask

  // entered in the strobe cycle; leaves in the done cycle
  task automatic frame_body(input int nbits, input int pulse_at, input bit hold, input bit zero_data);
    logic [11:0] rx;
    logic b;
    rx = '0;
    chk("fs_strobe", {31'd0, o_fs}, 1);
    chk("fs_busy", {31'd0, o_busy}, 1);
    chk("fs_sdo", {31'd0, o_sdo}, 0);
    if (zero_data) data_i = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      set_start(hold || (i == pulse_at));
      tick();
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL scoreboard_empty observed=%0h expected=queued_bit", o_sdo);
        b = 1'bx;
      end else b = exp_q.pop_front();
      chk("bit", {31'd0, o_sdo}, {31'd0, b});
      chk("bit_busy", {31'd0, o_busy}, 1);
      chk("bit_fs", {31'd0, o_fs}, 0);
      rx = {rx[10:0], o_sdo};
    end
    if (!hold) set_start(1'b0);
    tick();
    chk("done", {31'd0, o_done}, 1);
    chk("done_busy", {31'd0, o_busy}, 0);
    chk("done_sdo", {31'd0, o_sdo}, 0);
    chk("done_fs", {31'd0, o_fs}, 0);
    rx_word = rx;
  endtask

  initial begin
    sel = 1'b0; start_nf = 1'b0;
    rst = 1'b1; start_i = 1'b1; data_i = 8'hA5; flags_i = 4'hA;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_fs", {31'd0, fs}, 0);
    chk("rst_sdo", {31'd0, sdo}, 0);
    chk("rst_nf_busy", {31'd0, nf_busy}, 0);
    rst = 1'b0; start_i = 1'b0;
    tick();
    chk("rst_no_frame_fs", {31'd0, fs}, 0);
    chk("rst_no_frame_busy", {31'd0, busy}, 0);

    send(8'hA5, 4'b1010, 1'b0);
    frame_body(12, -1, 1'b0, 1'b0);
    chk("basic_word", {20'd0, rx_word}, 32'hA5A);
    tick();
    chk("done_pulse_once", {31'd0, done}, 0);

    send(8'hA5, 4'b1010, 1'b0);
    frame_body(12, -1, 1'b0, 1'b1);
    chk("stable_word", {20'd0, rx_word}, 32'hA5A);
    tick();

    send(8'h5A, 4'b0110, 1'b1);
    push_frame(8'h5A, 4'b0110, 1'b1);
    frame_body(12, -1, 1'b1, 1'b0);
    chk("b2b_first", {20'd0, rx_word}, 32'h5A6);
    tick();
    start_i = 1'b0;
    frame_body(12, -1, 1'b0, 1'b0);
    chk("b2b_second", {20'd0, rx_word}, 32'h5A6);

    send(8'hC3, 4'b0101, 1'b0);
    frame_body(12, 3, 1'b0, 1'b0);
    chk("pulse_word", {20'd0, rx_word}, 32'hC35);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ignored_fs", {31'd0, fs}, 0);
      chk("ignored_busy", {31'd0, busy}, 0);
    end

    send(8'hA5, 4'b1010, 1'b0);
    chk("mr_fs", {31'd0, fs}, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_bit", {31'd0, sdo}, {31'd0, exp_q.pop_front()});
    end
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_done", {31'd0, done}, 0);
    chk("mr_fs0", {31'd0, fs}, 0);
    chk("mr_sdo", {31'd0, sdo}, 0);
    tick();
    chk("mr_no_done", {31'd0, done}, 0);
    chk("mr_idle_busy", {31'd0, busy}, 0);
    send(8'h3C, 4'b0001, 1'b0);
    frame_body(12, -1, 1'b0, 1'b0);
    chk("mr_word", {20'd0, rx_word}, 32'h3C1);
    tick();

    sel = 1'b1;
    send(8'hFF, 4'b1111, 1'b0);
    frame_body(8, -1, 1'b0, 1'b0);
    chk("nf_word", {24'd0, rx_word[7:0]}, 32'hFF);
    tick();
    chk("nf_done_once", {31'd0, nf_done}, 0);
    sel = 1'b0;

    send(8'd10 + 8'd5, 4'b0000, 1'b0);
    frame_body(12, -1, 1'b0, 1'b0);
    chk("e2e_y", {24'd0, rx_word[11:4]}, 32'd15);
    chk("e2e_flags", {28'd0, rx_word[3:0]}, 32'd0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
